connect4_board_state: RTL and testbench



---
 rtl/connect4_board_state.sv | 236 +++++++++++++++++++++++
 tb/tb_connect4_board_state.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/connect4_board_state.sv
// connect4_board_state
//   Board store for a 4x4 Connect4 game. Validates a requested cell, writes it
//   into the current player's bitmap, bumps the column fill counter, then
//   checks for a win or draw and passes the turn on.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   new_game       in   synchronous clear of the whole game (highest priority)
//   move_stb       in   one-cycle move request, sampled only while idle
//   cell_index[4:0] in  target cell, row*4 + col (row 0 = bottom), 31 = none
//   counters[11:0] out  per-column fill count, column c at [3c+2:3c]
//   board_p1[15:0] out  cells owned by player 1
//   board_p2[15:0] out  cells owned by player 2
//   current_player out  0 = player 1 to move, 1 = player 2 to move
//   busy           out  move in flight (PLACE or CHECK)
//   move_done      out  one-cycle pulse when an accepted move commits
//   illegal        out  one-cycle pulse when a sampled request is rejected
//   winner[1:0]    out  00 none, 01 player 1, 10 player 2, 11 draw
//   game_over      out  high once winner is non-zero
module connect4_board_state (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game,
  input  logic        move_stb,
  input  logic [4:0]  cell_index,
  output logic [11:0] counters,
  output logic [15:0] board_p1,
  output logic [15:0] board_p2,
  output logic        current_player,
  output logic        busy,
  output logic        move_done,
  output logic        illegal,
  output logic [1:0]  winner,
  output logic        game_over
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLACE = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cell_q, cell_d;
  logic [11:0] counters_q, counters_d;
  logic [15:0] board_p1_q, board_p1_d;
  logic [15:0] board_p2_q, board_p2_d;
  logic        player_q, player_d;
  logic        busy_q, busy_d;
  logic        move_done_q, move_done_d;
  logic        illegal_q, illegal_d;
  logic [1:0]  winner_q, winner_d;
  logic        game_over_q, game_over_d;

  logic [2:0]  cnt_s;
  logic [15:0] occ_s;
  logic        legal_s;
  logic [15:0] place_mask_s;
  logic [15:0] mover_board_s;

  // Fill level of one column taken from the packed counter vector.
  function automatic logic [2:0] col_count(input logic [11:0] cnts, input logic [1:0] col);
    logic [2:0] val;
    case (col)
      2'd0:    val = cnts[2:0];
      2'd1:    val = cnts[5:3];
      2'd2:    val = cnts[8:6];
      2'd3:    val = cnts[11:9];
      default: val = 3'd0;
    endcase
    return val;
  endfunction

  // Packed counter vector with one column incremented. Validation keeps every
  // column at or below 4, so the 3-bit add never wraps.
  function automatic logic [11:0] col_bump(input logic [11:0] cnts, input logic [1:0] col);
    logic [11:0] res;
    res = cnts;
    case (col)
      2'd0:    res[2:0]  = cnts[2:0]  + 3'd1;
      2'd1:    res[5:3]  = cnts[5:3]  + 3'd1;
      2'd2:    res[8:6]  = cnts[8:6]  + 3'd1;
      2'd3:    res[11:9] = cnts[11:9] + 3'd1;
      default: res = cnts;
    endcase
    return res;
  endfunction

  // True when the bitmap fully covers one of the ten winning lines.
  function automatic logic has_line(input logic [15:0] b);
    logic hit;
    hit = 1'b0;
    hit = hit | ((b & 16'h000F) == 16'h000F);   // row 0
    hit = hit | ((b & 16'h00F0) == 16'h00F0);   // row 1
    hit = hit | ((b & 16'h0F00) == 16'h0F00);   // row 2
    hit = hit | ((b & 16'hF000) == 16'hF000);   // row 3
    hit = hit | ((b & 16'h1111) == 16'h1111);   // col 0
    hit = hit | ((b & 16'h2222) == 16'h2222);   // col 1
    hit = hit | ((b & 16'h4444) == 16'h4444);   // col 2
    hit = hit | ((b & 16'h8888) == 16'h8888);   // col 3
    hit = hit | ((b & 16'h8421) == 16'h8421);   // cells 0,5,10,15
    hit = hit | ((b & 16'h1248) == 16'h1248);   // cells 3,6,9,12
    return hit;
  endfunction

  // Move validation against the registered board; row must equal the fill
  // level so pieces always land on top of their column.
  always_comb begin
    cnt_s   = col_count(counters_q, cell_index[1:0]);
    occ_s   = board_p1_q | board_p2_q;
    legal_s = (cell_index[4] == 1'b0) &&
              (cnt_s < 3'd4) &&
              (cell_index[4:2] == cnt_s) &&
              (occ_s[cell_index[3:0]] == 1'b0) &&
              (game_over_q == 1'b0);
  end

  // Placement mask for the latched cell and the bitmap of the player who moved.
  always_comb begin
    place_mask_s = 16'h0001 << cell_q;
    if (player_q) begin
      mover_board_s = board_p2_q;
    end else begin
      mover_board_s = board_p1_q;
    end
  end

  // Next-state and next-output logic of the move sequencer.
  always_comb begin
    state_d     = state_q;
    cell_d      = cell_q;
    counters_d  = counters_q;
    board_p1_d  = board_p1_q;
    board_p2_d  = board_p2_q;
    player_d    = player_q;
    move_done_d = 1'b0;
    illegal_d   = 1'b0;
    winner_d    = winner_q;
    game_over_d = game_over_q;

    if (new_game) begin
      state_d     = ST_IDLE;
      cell_d      = 4'd0;
      counters_d  = 12'd0;
      board_p1_d  = 16'd0;
      board_p2_d  = 16'd0;
      player_d    = 1'b0;
      winner_d    = 2'b00;
      game_over_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (move_stb) begin
            if (legal_s) begin
              cell_d  = cell_index[3:0];
              state_d = ST_PLACE;
            end else begin
              illegal_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PLACE: begin
          if (player_q) begin
            board_p2_d = board_p2_q | place_mask_s;
          end else begin
            board_p1_d = board_p1_q | place_mask_s;
          end
          counters_d = col_bump(counters_q, cell_q[1:0]);
          state_d    = ST_CHECK;
        end
        ST_CHECK: begin
          // Board is already updated here, so only the mover can have won.
          if (has_line(mover_board_s)) begin
            winner_d    = player_q ? 2'b10 : 2'b01;
            game_over_d = 1'b1;
          end else if ((board_p1_q | board_p2_q) == 16'hFFFF) begin
            winner_d    = 2'b11;
            game_over_d = 1'b1;
          end else begin
            player_d = ~player_q;
          end
          move_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cell_q      <= 4'd0;
      counters_q  <= 12'd0;
      board_p1_q  <= 16'd0;
      board_p2_q  <= 16'd0;
      player_q    <= 1'b0;
      busy_q      <= 1'b0;
      move_done_q <= 1'b0;
      illegal_q   <= 1'b0;
      winner_q    <= 2'b00;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cell_q      <= cell_d;
      counters_q  <= counters_d;
      board_p1_q  <= board_p1_d;
      board_p2_q  <= board_p2_d;
      player_q    <= player_d;
      busy_q      <= busy_d;
      move_done_q <= move_done_d;
      illegal_q   <= illegal_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
    end
  end

  assign counters       = counters_q;
  assign board_p1       = board_p1_q;
  assign board_p2       = board_p2_q;
  assign current_player = player_q;
  assign busy           = busy_q;
  assign move_done      = move_done_q;
  assign illegal        = illegal_q;
  assign winner         = winner_q;
  assign game_over      = game_over_q;

endmodule

// File: tb/tb_connect4_board_state.sv
// Directed bench for connect4_board_state. Inputs change on the falling edge,
// outputs are sampled on the falling edge, away from the rising active edge.
module tb_connect4_board_state;

  logic        clk;
  logic        rst_n;
  logic        new_game;
  logic        move_stb;
  logic [4:0]  cell_index;
  logic [11:0] counters;
  logic [15:0] board_p1;
  logic [15:0] board_p2;
  logic        current_player;
  logic        busy;
  logic        move_done;
  logic        illegal;
  logic [1:0]  winner;
  logic        game_over;

  int total;
  int bad;

  // Expected move observation {illegal@N+1, busy@N+1, busy@N+2, illegal@N+2, move_done@N+3}
  localparam logic [4:0] OBS_LEGAL   = 5'b01101;
  localparam logic [4:0] OBS_ILLEGAL = 5'b10000;

  connect4_board_state dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .new_game       (new_game),
    .move_stb       (move_stb),
    .cell_index     (cell_index),
    .counters       (counters),
    .board_p1       (board_p1),
    .board_p2       (board_p2),
    .current_player (current_player),
    .busy           (busy),
    .move_done      (move_done),
    .illegal        (illegal),
    .winner         (winner),
    .game_over      (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and records the handshake over cycles N+1..N+3.
  task automatic move(input logic [4:0] idx, output logic [4:0] obs);
    @(negedge clk);
    move_stb = 1'b1;
    cell_index = idx;
    @(negedge clk);
    move_stb = 1'b0;
    cell_index = 5'b11111;
    obs[4] = illegal;
    obs[3] = busy;
    @(negedge clk);
    obs[2] = busy;
    obs[1] = illegal;
    @(negedge clk);
    obs[0] = move_done;
  endtask

  task automatic start_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    new_game = 1'b0;
    move_stb = 1'b0;
    cell_index = 5'b11111;
    repeat (3) @(negedge clk);
    total++;
    if ({counters, board_p1, board_p2} !== 44'd0) begin
      bad++;
      $display("FAIL reset_board: got %h %h %h want 0", counters, board_p1, board_p2);
    end
    total++;
    if ({current_player, busy, move_done, illegal, winner, game_over} !== 7'd0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000000",
               {current_player, busy, move_done, illegal, winner, game_over});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_move();
    @(negedge clk);
    move_stb = 1'b1;
    cell_index = 5'd0;
    @(negedge clk);  // N+1
    move_stb = 1'b0;
    cell_index = 5'b11111;
    total++;
    if ({busy, illegal, board_p1, counters} !== {1'b1, 1'b0, 16'h0000, 12'h000}) begin
      bad++;
      $display("FAIL first_n1: busy=%b ill=%b p1=%h cnt=%h want 1 0 0000 000", busy, illegal, board_p1, counters);
    end
    @(negedge clk);  // N+2
    total++;
    if ({busy, move_done, board_p1, counters, current_player} !== {1'b1, 1'b0, 16'h0001, 12'h001, 1'b0}) begin
      bad++;
      $display("FAIL first_n2: busy=%b done=%b p1=%h cnt=%h pl=%b want 1 0 0001 001 0",
               busy, move_done, board_p1, counters, current_player);
    end
    @(negedge clk);  // N+3
    total++;
    if ({busy, move_done, current_player, winner} !== {1'b0, 1'b1, 1'b1, 2'b00}) begin
      bad++;
      $display("FAIL first_n3: busy=%b done=%b pl=%b win=%b want 0 1 1 00", busy, move_done, current_player, winner);
    end
    @(negedge clk);  // N+4
    total++;
    if (move_done !== 1'b0) begin
      bad++;
      $display("FAIL first_done_width: done=%b want 0", move_done);
    end
  endtask

  task automatic test_column_fill();
    logic [4:0] obs;
    start_new_game();
    total++;
    if ({counters, board_p1, board_p2, current_player} !== 45'd0) begin
      bad++;
      $display("FAIL newgame_clear: cnt=%h p1=%h p2=%h pl=%b want 0", counters, board_p1, board_p2, current_player);
    end
    for (int i = 0; i < 4; i++) begin
      move(5'd2 + 5'(4 * i), obs);
      total++;
      if (obs !== OBS_LEGAL) begin
        bad++;
        $display("FAIL fill_move%0d: obs=%b want %b", i, obs, OBS_LEGAL);
      end
    end
    total++;
    if ({counters, board_p1, board_p2, current_player} !== {12'h100, 16'h0404, 16'h4040, 1'b0}) begin
      bad++;
      $display("FAIL fill_state: cnt=%h p1=%h p2=%h pl=%b want 100 0404 4040 0", counters, board_p1, board_p2, current_player);
    end
    move(5'b11111, obs);
    total++;
    if (obs !== OBS_ILLEGAL) begin
      bad++;
      $display("FAIL fill_nocell: obs=%b want %b", obs, OBS_ILLEGAL);
    end
    move(5'd18, obs);
    total++;
    if (obs !== OBS_ILLEGAL) begin
      bad++;
      $display("FAIL fill_idx18: obs=%b want %b", obs, OBS_ILLEGAL);
    end
    total++;
    if ({counters, board_p1, board_p2, current_player, winner} !== {12'h100, 16'h0404, 16'h4040, 1'b0, 2'b00}) begin
      bad++;
      $display("FAIL fill_unchanged: cnt=%h p1=%h p2=%h pl=%b win=%b", counters, board_p1, board_p2, current_player, winner);
    end
  endtask

  task automatic test_illegal();
    logic [4:0] obs;
    start_new_game();
    move(5'd4, obs);
    total++;
    if (obs !== OBS_ILLEGAL) begin
      bad++;
      $display("FAIL ill_wrong_row: obs=%b want %b", obs, OBS_ILLEGAL);
    end
    move(5'd18, obs);
    total++;
    if (obs !== OBS_ILLEGAL) begin
      bad++;
      $display("FAIL ill_idx18: obs=%b want %b", obs, OBS_ILLEGAL);
    end
    total++;
    if ({counters, board_p1, board_p2, current_player} !== 45'd0) begin
      bad++;
      $display("FAIL ill_unchanged: cnt=%h p1=%h p2=%h pl=%b want 0", counters, board_p1, board_p2, current_player);
    end
    move(5'd0, obs);
    move(5'd0, obs);
    total++;
    if (obs !== OBS_ILLEGAL) begin
      bad++;
      $display("FAIL ill_occupied: obs=%b want %b", obs, OBS_ILLEGAL);
    end
    total++;
    if ({counters, board_p1, board_p2, current_player} !== {12'h001, 16'h0001, 16'h0000, 1'b1}) begin
      bad++;
      $display("FAIL ill_after_occ: cnt=%h p1=%h p2=%h pl=%b want 001 0001 0000 1", counters, board_p1, board_p2, current_player);
    end
  endtask

  task automatic test_vertical_win();
    logic [4:0] obs;
    logic [4:0] seq [7] = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd8, 5'd9, 5'd12};
    start_new_game();
    for (int i = 0; i < 7; i++) begin
      move(seq[i], obs);
      total++;
      if (obs !== OBS_LEGAL) begin
        bad++;
        $display("FAIL vwin_move%0d: obs=%b want %b", i, obs, OBS_LEGAL);
      end
    end
    total++;
    if ({winner, game_over, current_player, board_p1, board_p2} !== {2'b01, 1'b1, 1'b0, 16'h1111, 16'h0222}) begin
      bad++;
      $display("FAIL vwin_result: win=%b go=%b pl=%b p1=%h p2=%h want 01 1 0 1111 0222",
               winner, game_over, current_player, board_p1, board_p2);
    end
    move(5'd13, obs);
    total++;
    if (obs !== OBS_ILLEGAL) begin
      bad++;
      $display("FAIL vwin_after: obs=%b want %b", obs, OBS_ILLEGAL);
    end
    total++;
    if ({winner, game_over, counters} !== {2'b01, 1'b1, 12'h01C}) begin
      bad++;
      $display("FAIL vwin_hold: win=%b go=%b cnt=%h want 01 1 01c", winner, game_over, counters);
    end
  endtask

  task automatic test_diag_win();
    logic [4:0] obs;
    logic [4:0] seq [10] = '{5'd0, 5'd4, 5'd8, 5'd12, 5'd1, 5'd3, 5'd5, 5'd9, 5'd2, 5'd6};
    start_new_game();
    for (int i = 0; i < 10; i++) begin
      move(seq[i], obs);
      total++;
      if (obs !== OBS_LEGAL) begin
        bad++;
        $display("FAIL dwin_move%0d: obs=%b want %b", i, obs, OBS_LEGAL);
      end
      if (i == 8) begin
        total++;
        if ({winner, game_over} !== {2'b00, 1'b0}) begin
          bad++;
          $display("FAIL dwin_early: win=%b go=%b want 00 0", winner, game_over);
        end
      end
    end
    total++;
    if ({winner, game_over, current_player, board_p1, board_p2, counters} !==
        {2'b10, 1'b1, 1'b1, 16'h0127, 16'h1258, 12'h29C}) begin
      bad++;
      $display("FAIL dwin_result: win=%b go=%b pl=%b p1=%h p2=%h cnt=%h want 10 1 1 0127 1258 29c",
               winner, game_over, current_player, board_p1, board_p2, counters);
    end
  endtask

  task automatic test_draw();
    logic [4:0] obs;
    logic [4:0] seq [16] = '{5'd0, 5'd2, 5'd1, 5'd3, 5'd6, 5'd4, 5'd7, 5'd5,
                             5'd8, 5'd10, 5'd9, 5'd11, 5'd14, 5'd12, 5'd15, 5'd13};
    start_new_game();
    for (int i = 0; i < 16; i++) begin
      move(seq[i], obs);
      total++;
      if (obs !== OBS_LEGAL) begin
        bad++;
        $display("FAIL draw_move%0d: obs=%b want %b", i, obs, OBS_LEGAL);
      end
      if (i == 14) begin
        total++;
        if ({winner, game_over, current_player} !== {2'b00, 1'b0, 1'b1}) begin
          bad++;
          $display("FAIL draw_15th: win=%b go=%b pl=%b want 00 0 1", winner, game_over, current_player);
        end
      end
    end
    total++;
    if ({winner, game_over, current_player, board_p1, board_p2, counters} !==
        {2'b11, 1'b1, 1'b1, 16'hC3C3, 16'h3C3C, 12'h924}) begin
      bad++;
      $display("FAIL draw_result: win=%b go=%b pl=%b p1=%h p2=%h cnt=%h want 11 1 1 c3c3 3c3c 924",
               winner, game_over, current_player, board_p1, board_p2, counters);
    end
  endtask

  task automatic test_abort_and_busy();
    start_new_game();
    // new_game during PLACE aborts the move
    @(negedge clk);
    move_stb = 1'b1;
    cell_index = 5'd0;
    @(negedge clk);  // PLACE cycle
    move_stb = 1'b0;
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    total++;
    if ({board_p1, counters, busy, move_done} !== {16'h0000, 12'h000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL abort_n2: p1=%h cnt=%h busy=%b done=%b want 0000 000 0 0", board_p1, counters, busy, move_done);
    end
    @(negedge clk);
    total++;
    if ({move_done, board_p1} !== {1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL abort_n3: done=%b p1=%h want 0 0000", move_done, board_p1);
    end
    // move_stb held during PLACE and CHECK must be dropped silently
    @(negedge clk);
    move_stb = 1'b1;
    cell_index = 5'd0;
    @(negedge clk);  // N+1
    cell_index = 5'd4;
    total++;
    if ({busy, illegal} !== 2'b10) begin
      bad++;
      $display("FAIL busy_n1: busy=%b ill=%b want 1 0", busy, illegal);
    end
    @(negedge clk);  // N+2
    total++;
    if ({busy, illegal} !== 2'b10) begin
      bad++;
      $display("FAIL busy_n2: busy=%b ill=%b want 1 0", busy, illegal);
    end
    @(negedge clk);  // N+3
    move_stb = 1'b0;
    cell_index = 5'b11111;
    total++;
    if ({move_done, illegal} !== 2'b10) begin
      bad++;
      $display("FAIL busy_n3: done=%b ill=%b want 1 0", move_done, illegal);
    end
    @(negedge clk);
    total++;
    if ({busy, illegal, counters, board_p1, board_p2} !== {1'b0, 1'b0, 12'h001, 16'h0001, 16'h0000}) begin
      bad++;
      $display("FAIL busy_drop: busy=%b ill=%b cnt=%h p1=%h p2=%h want 0 0 001 0001 0000",
               busy, illegal, counters, board_p1, board_p2);
    end
    // new_game with a simultaneous (otherwise legal) move_stb
    move_stb = 1'b1;
    cell_index = 5'd4;
    new_game = 1'b1;
    @(negedge clk);
    move_stb = 1'b0;
    new_game = 1'b0;
    cell_index = 5'b11111;
    total++;
    if ({busy, illegal, counters, board_p1, current_player} !== {1'b0, 1'b0, 12'h000, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL newgame_vs_stb: busy=%b ill=%b cnt=%h p1=%h pl=%b want 0 0 000 0000 0",
               busy, illegal, counters, board_p1, current_player);
    end
  endtask

  task automatic test_async_reset_midgame();
    logic [4:0] obs;
    move(5'd0, obs);
    move(5'd1, obs);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({counters, board_p1, board_p2, current_player, winner, game_over} !== 48'd0) begin
      bad++;
      $display("FAIL async_reset: cnt=%h p1=%h p2=%h pl=%b win=%b go=%b want 0",
               counters, board_p1, board_p2, current_player, winner, game_over);
    end
    @(negedge clk);
    rst_n = 1'b1;
    move(5'd0, obs);
    total++;
    if ({obs, board_p1, counters, current_player} !== {OBS_LEGAL, 16'h0001, 12'h001, 1'b1}) begin
      bad++;
      $display("FAIL after_reset_move: obs=%b p1=%h cnt=%h pl=%b want %b 0001 001 1",
               obs, board_p1, counters, current_player, OBS_LEGAL);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_first_move();
    test_column_fill();
    test_illegal();
    test_vertical_win();
    test_diag_win();
    test_draw();
    test_abort_and_busy();
    test_async_reset_midgame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
